// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
// The PARITY state is only reachable in builds with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int DEFAULT_BAUD_DIV = 1252;

    // A counter must always have at least one bit, even for n=1 or n=2.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter with synchronous clear.
// o_tick pulses for one cycle when the count reaches BAUD_DIV-1.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST) && !i_clr;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// FIFO-draining UART transmitter, 8N1 LSB first with registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int DATA_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int IW = cnt_width(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [IW-1:0]     r_idx;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_tick;
    logic              w_clr;
    logic              w_start;
    logic              w_last_bit;

`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    assign w_start    = en && !fifo_empty && !reset;
    assign w_last_bit = (r_idx == LAST_BIT);
    assign w_clr      = (r_state == IDLE) || (r_state == FETCH);
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || fifo_rd;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .i_clock(clock),
        .i_reset(reset),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_start) w_next = FETCH;
            FETCH: w_next = START;
            START: if (w_tick) w_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (w_tick && w_last_bit) w_next = PARITY;
            PARITY: if (w_tick) w_next = STOP;
`else
            DATA:   if (w_tick && w_last_bit) w_next = STOP;
            PARITY: w_next = IDLE;
`endif
            STOP:  if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd      = 1'b0;
        tx_done      = 1'b0;
        w_shift_next = r_shift;
        unique case (r_state)
            IDLE:  fifo_rd = w_start;
            FETCH: w_shift_next = fifo_data;
            DATA:  if (w_tick) w_shift_next = r_shift >> 1;
            STOP:  tx_done = w_tick;
            default: ;
        endcase

        // tx is registered, so its next level follows the next state.
        case (w_next)
            START:   w_tx_next = START_LEVEL;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            STOP:    w_tx_next = STOP_LEVEL;
            default: w_tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx    <= IDLE_LEVEL;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_tx    <= w_tx_next;
            r_shift <= w_shift_next;
            if (r_state == DATA && w_tick) begin
                r_idx <= w_last_bit ? '0 : r_idx + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (r_state == FETCH) begin
            r_parity <= ^fifo_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx: fast divider instance plus
// a default-divider instance for bit-period measurement.
module tb_uart_fifo_tx;

    localparam int DA = 4;
    localparam int DB = 1252;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = DW + 2 + PB;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       a_en = 1'b0;
    logic       a_empty;
    logic       a_rd;
    logic [7:0] a_data = 8'h00;
    logic       a_tx, a_busy, a_done;

    logic       b_en = 1'b0;
    logic       b_empty = 1'b1;
    logic       b_rd;
    logic [7:0] b_data = 8'h55;
    logic       b_tx, b_busy, b_done;

    uart_fifo_tx #(.BAUD_DIV(DA), .DATA_W(DW)) u_a (
        .clock(clock), .reset(reset), .en(a_en),
        .fifo_empty(a_empty), .fifo_rd(a_rd), .fifo_data(a_data),
        .tx(a_tx), .busy(a_busy), .tx_done(a_done)
    );

    uart_fifo_tx u_b (
        .clock(clock), .reset(reset), .en(b_en),
        .fifo_empty(b_empty), .fifo_rd(b_rd), .fifo_data(b_data),
        .tx(b_tx), .busy(b_busy), .tx_done(b_done)
    );

    // Behavioural FIFO feeding instance A: data valid the cycle after a read.
    logic [7:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    assign a_empty = (wp == rp);
    always @(posedge clock) begin
        if (a_rd) begin
            a_data <= mem[rp % 64];
            rp     <= rp + 1;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic sel = 1'b0;
    logic m_tx, m_rd, m_busy, m_done;
    assign m_tx   = sel ? b_tx   : a_tx;
    assign m_rd   = sel ? b_rd   : a_rd;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;

    int n_cmp = 0;
    int n_bad = 0;
    int edges[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @cyc %0d: got %0h want %0h",
                         nm, cyc, act, exp);
        end
    endtask

    // Frame levels in time order: start, data LSB first, [parity], stop.
    function automatic logic [15:0] frame_of(input logic [7:0] d,
                                             input logic p);
        logic [15:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1 + i] = d[i];
        if (PB == 1) f[DW + 1] = p;
        f[FB - 1] = 1'b1;
        return f;
    endfunction

    task automatic push(input logic [7:0] d);
        mem[wp % 64] = d;
        wp++;
    endtask

    task automatic wait_rd(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (m_rd) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    task automatic idle_check(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk({nm, ".rd"}, {31'd0, m_rd}, 32'd0);
            chk({nm, ".tx"}, {31'd0, m_tx}, 32'd1);
            chk({nm, ".busy"}, {31'd0, m_busy}, 32'd0);
        end
    endtask

    // Entered at the negedge of the fifo_rd cycle (k=0).
    task automatic check_frame(input logic [7:0] d, input logic p,
                               input int drop_at);
        int D;
        int last;
        logic [15:0] f;
        logic prev;
        logic etx;
        D    = sel ? DB : DA;
        last = 2 + FB * D - 1;
        f    = frame_of(d, p);
        prev = 1'b1;
        edges.delete();
        for (int k = 0; k <= last; k++) begin
            if (k > 0) @(negedge clock);
            etx = (k < 2) ? 1'b1 : f[(k - 2) / D];
            chk("frame.tx", {31'd0, m_tx}, {31'd0, etx});
            chk("frame.rd", {31'd0, m_rd}, {31'd0, k == 0});
            chk("frame.busy", {31'd0, m_busy}, 32'd1);
            chk("frame.done", {31'd0, m_done}, {31'd0, k == last});
            if (m_tx !== prev) edges.push_back(k);
            prev = m_tx;
            if (k == drop_at) begin
                if (sel) b_en = 1'b0;
                else a_en = 1'b0;
            end
            if (sel && k == 1) b_empty = 1'b1;
        end
    endtask

    initial begin
        vec_t tv[6];
        int r1, r2;
        int exp_e[$];
        logic [15:0] f;
        logic prev;
        logic [7:0] d;
        int drop;

        tv[0] = '{8'hA5, 1'b0};
        tv[1] = '{8'h07, 1'b1};
        tv[2] = '{8'h03, 1'b0};
        tv[3] = '{8'h01, 1'b1};
        tv[4] = '{8'h80, 1'b1};
        tv[5] = '{8'hE7, 1'b0};

        repeat (3) @(negedge clock);
        chk("rst.tx", {31'd0, a_tx}, 32'd1);
        chk("rst.rd", {31'd0, a_rd}, 32'd0);
        chk("rst.busy", {31'd0, a_busy}, 32'd0);
        chk("rst.done", {31'd0, a_done}, 32'd0);
        chk("rst.b_tx", {31'd0, b_tx}, 32'd1);
        reset = 1'b0;

        a_en = 1'b1;
        idle_check(100, "gate_empty");
        @(posedge clock); #1;
        a_en = 1'b0;
        push(8'h5A);
        idle_check(100, "gate_en");
        @(posedge clock); #1;
        a_en = 1'b1;
        wait_rd(4, "gate_release.rd");
        check_frame(8'h5A, 1'b0, -1);
        idle_check(2, "gate_release.idle");

        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            push(tv[i].data);
            wait_rd(4, "vec.rd");
            check_frame(tv[i].data, tv[i].par, -1);
            idle_check(2, "vec.idle");
        end

        @(posedge clock); #1;
        push(8'h00);
        push(8'hFF);
        wait_rd(4, "b2b.rd1");
        r1 = cyc;
        check_frame(8'h00, 1'b0, -1);
        wait_rd(1, "b2b.rd2");
        r2 = cyc;
        chk("b2b.gap", r2 - r1, FB * DA + 2);
        check_frame(8'hFF, 1'b0, -1);
        idle_check(2, "b2b.idle");

        @(posedge clock); #1;
        push(8'h3C);
        push(8'h11);
        wait_rd(4, "endrop.rd");
        check_frame(8'h3C, 1'b0, 2 + 3 * DA);
        idle_check(20, "endrop.idle");
        @(posedge clock); #1;
        a_en = 1'b1;
        wait_rd(4, "endrop.resume");
        check_frame(8'h11, 1'b0, -1);
        idle_check(2, "endrop.after");

        @(posedge clock); #1;
        push(8'hC3);
        wait_rd(4, "rstmid.rd");
        for (int k = 1; k <= 2 + 4 * DA + 1; k++) @(negedge clock);
        chk("rstmid.pre_tx", {31'd0, a_tx}, 32'd0);
        chk("rstmid.pre_busy", {31'd0, a_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid.tx", {31'd0, a_tx}, 32'd1);
        chk("rstmid.busy", {31'd0, a_busy}, 32'd0);
        chk("rstmid.rd", {31'd0, a_rd}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle_check(3, "rstmid.idle");
        @(posedge clock); #1;
        push(8'h96);
        wait_rd(4, "rstmid.next_rd");
        check_frame(8'h96, 1'b0, -1);
        idle_check(2, "rstmid.after");

        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 5)) @(posedge clock);
            @(posedge clock); #1;
            d = 8'($urandom);
            drop = ($urandom_range(0, 1) == 1)
                 ? int'($urandom_range(2, 2 + FB * DA - 1)) : -1;
            push(d);
            wait_rd(4, "rand.rd");
            check_frame(d, 1'($countones(d) % 2), drop);
            idle_check(1, "rand.idle");
            @(posedge clock); #1;
            a_en = 1'b1;
        end

        sel = 1'b1;
        @(posedge clock); #1;
        b_en = 1'b1;
        b_empty = 1'b0;
        wait_rd(4, "div.rd");
        check_frame(8'h55, 1'b0, -1);
        f = frame_of(8'h55, 1'b0);
        prev = 1'b1;
        for (int i = 0; i < FB; i++) begin
            if (f[i] != prev) exp_e.push_back(2 + i * DB);
            prev = f[i];
        end
        chk("div.edge_count", edges.size(), exp_e.size());
        for (int i = 0; i < exp_e.size() && i < edges.size(); i++) begin
            chk("div.edge_at", edges[i], exp_e[i]);
            if (i > 0)
                chk("div.period", edges[i] - edges[i - 1],
                    exp_e[i] - exp_e[i - 1]);
        end
        idle_check(2, "div.idle");
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- Serial transmitter that drains the team's byte FIFO through its read/empty handshake and sends each byte as an 8N1 UART frame, LSB first.
- Sits downstream of the FIFO buffer. It is the reader side of the FIFO's write-then-read interface and drives the board TX pin.
- Owns its own baud timing, derived from the system clock, instead of using a divided clock domain.

Parameters:
- BAUD_DIV, 1252, system clock cycles per serial bit; legal range 2..65535.
- DATA_W, 8, data bits per frame.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  permits starting new frames.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  one-cycle read strobe to the FIFO.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the fifo_rd cycle through the last stop cycle.
- tx_done  out  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: tx=1, fifo_rd=0, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- State machine states: IDLE, FETCH, START, DATA, STOP (PARITY when the optional feature is compiled in).
- IDLE:
  - If en=1 and fifo_empty=0 in cycle N, fifo_rd=1 in cycle N. fifo_rd is a Mealy output, combinational from the state and inputs.
  - State moves to FETCH at N+1.
  - Otherwise remain in IDLE with tx=1.
- FETCH:
  - fifo_data is loaded into the shift register at the end of cycle N+1. The state moves to START and the baud counter clears.
- START: tx=0 for exactly BAUD_DIV cycles, beginning at N+2.
- DATA:
  - tx is driven from shift register bit 0 for BAUD_DIV cycles per bit, then the register shifts right.
  - Runs for DATA_W bits. The bit index counts 0..DATA_W-1 and then clears.
- STOP:
  - tx=1 for BAUD_DIV cycles. tx_done=1 on the last of those cycles, then return to IDLE.
  - Back-to-back frames have exactly 2 extra high cycles (IDLE + FETCH) between the stop bit and the next start bit.
- Frame length: one frame is 1 + DATA_W + 1 bits. tx is registered and glitch-free.
- Baud counter: counts 0..BAUD_DIV-1; the bit boundary is at BAUD_DIV-1. Its width is clog2(BAUD_DIV).
- en deasserted mid-frame: the current frame completes unchanged, and no new fifo_rd is issued.
- fifo_empty going high mid-frame: ignored.
- fifo_rd never asserts while fifo_empty=1, nor in any state other than IDLE.
- Reset mid-frame: tx returns high immediately (asynchronously) and the frame is abandoned. The FIFO byte already read is lost.
- busy=1 in every state except IDLE, plus the IDLE cycle in which fifo_rd=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP.
  - tx = XOR of the DATA_W data bits (even parity), held for BAUD_DIV cycles.
  - The parity is computed at the FETCH load.
  - Frame length becomes DATA_W+3 bits.
- When undefined: no PARITY state, no parity logic; frames are 8N1.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t (IDLE, FETCH, START, DATA, STOP, PARITY).
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
  - default BAUD_DIV.
  - function for baud counter width.
- Sub-module baud_tick_gen (parameter BAUD_DIV):
  - Counter with sync clear input and a one-cycle tick output at count BAUD_DIV-1.
  - Reusable by the matching receiver.

Test Plan (BAUD_DIV=4 unless noted):
- Single byte: fifo_data=8'hA5 available, en=1 -> fifo_rd one cycle; tx line 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 4 cycles; tx_done pulse at cycle N+41; busy low afterwards.
- Back-to-back: FIFO holds 8'h00 then 8'hFF -> two fifo_rd pulses 42 cycles apart; exactly 2 high cycles between the first stop bit and the second start bit; second frame is all-ones data.
- Gating: fifo_empty=1 or en=0 for 100 cycles -> fifo_rd never asserted, tx constant 1. Dropping en during the DATA bits of 8'h3C -> the frame completes, then no further reads.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 in the same cycle (asynchronous), busy=0; after release, the next byte is transmitted cleanly from START.
- Parity build (UART_TX_PARITY_EN): 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; frame 11 bits, tx_done at N+45.
- Default divider: BAUD_DIV=1252 with 8'h55 -> each bit held exactly 1252 cycles; measured bit period matches in all 10 bits.
